riu_exec_stage: RTL and testbench
=================================

Name: riu_exec_stage

Overview:
- Combined decode, control and ALU execute stage for the RIU RV32I-subset single-issue core.
- Takes the instruction held in the EX stage plus the register-file read data and I/O input.
- Produces the ALU result and the register-file read addresses.
- Registers the one-cycle-later write-back controls (WB stage) and the hex/GPIO output register.
- Sits between the fetch register and the regfile write port.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CSR_IO_IN, 12'hF00, CSR address read by csrrw to return io_in.
- CSR_IO_OUT, 12'hF02, CSR address written by csrrw to drive hex_out.

Ports:
- clck  in  1  clock; all flops update on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (name kept per codebase convention; a 1 resets).
- instr  in  32  instruction in EX.
- rs1_data  in  32  regfile readdata1.
- rs2_data  in  32  regfile readdata2.
- io_in  in  32  switch/GPIO input.
- rs1_addr  out  5  equals instr[19:15].
- rs2_addr  out  5  equals instr[24:20].
- alu_result  out  32  combinational ALU R.
- alu_zero  out  1  combinational; 1 when alu_result==0.
- wb_we  out  1  registered regfile write enable.
- wb_rd  out  5  registered destination register.
- wb_data  out  32  registered write data.
- hex_out  out  32  registered GPIO/hex display value.

Behaviour:
- Decode fields (combinational):
  - opcode = instr[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25].
  - imm12 = [31:20], imm20 = [31:12].
- ALU B operand: alusrc ? {{20{imm12[11]}}, imm12} : rs2_data.
- aluop encoding (4 bits):
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 MUL (low 32), 6 MULH (signed×signed high), 7 MULHU (unsigned high).
  - 8 SLL, 9 SRL, 10 SRA, 12 SLT (signed, result 0/1), 13 SLTU.
  - Others yield 0.
  - Shifts use B[4:0] only.
- Supported instructions, opcode 0110011 (R-type):
  - funct7 0000000 with add, sll, slt, sltu, xor, srl, or, and.
  - funct7 0100000 with sub, sra.
  - funct7 0000001 with mul (f3 000), mulh (001), mulhu (011).
  - Controls: alusrc=0, regwrite=1, regsel=ALU.
- Opcode 0010011 (I-type): addi, slti, sltiu, xori, ori, andi, slli, srli (imm[11:5]=0), srai (imm[11:5]=0100000).
  - Controls: alusrc=1, regwrite=1, regsel=ALU.
- Opcode 0110111 (lui): regwrite=1, regsel=LUI.
- Opcode 1110011 with funct3=001 (csrrw):
  - imm12==CSR_IO_IN: regwrite=1, regsel=IN.
  - imm12==CSR_IO_OUT: gpio_we=1, regwrite=0.
- regsel encoding: 2'b00 IN, 2'b01 LUI, 2'b10 ALU.
- Any other encoding (including 32'h0) is a NOP: regwrite=0, gpio_we=0, alusrc=0, aluop=ADD.
- Registered stage, latency 1 cycle from instr to wb_*/hex_out:
  - wb_we <= regwrite.
  - wb_rd <= rd.
  - wb_data <= IN: io_in, LUI: {imm20, 12'b0}, ALU: alu_result.
  - hex_out <= rs1_data when gpio_we, else hold.
- Reset (asynchronous assert, synchronous-clean deassert by clock): wb_we=0, wb_rd=0, wb_data=0, hex_out=0.
- Reset mid-operation discards the pending write.
- Combinational outputs (rs1_addr, rs2_addr, alu_result, alu_zero) are not affected by reset.
- Writes to rd=x0 still assert wb_we; the regfile ignores x0.
- Arithmetic wraps modulo 2^32; no overflow flag.

Optional Feature:
- Macro RIU_MUL_EN.
- Defined: mul, mulh, mulhu are decoded as above.
- Undefined: funct7 0000001 encodings decode as NOP; aluop values 5-7 return 0 and the multiplier is not synthesized.

Decomposition:
- Package riu_pkg holds:
  - aluop_e enum (4-bit values above);
  - regsel_e enum;
  - opcode constants OP_R, OP_I, OP_LUI, OP_SYS;
  - funct3/funct7 constants;
  - CSR address defaults.
- One natural sub-module: riu_alu (A, B, aluop -> R, zero), purely combinational.
- Decode and control live in the top as combinational logic.

Test Plan:
- Reset asserted with instr=32'h0 -> wb_we=0, wb_data=0, hex_out=0.
- Release reset, NOP keeps wb_we=0.
- addi x1,x0,5 (32'h00500093) -> alu_result=5; next edge wb_we=1, wb_rd=1, wb_data=5.
- sub (32'h40208133) with rs1_data=3, rs2_data=5 -> wb_data=32'hFFFFFFFE, alu_zero=0.
- Same instruction with rs1_data=rs2_data=7 -> alu_zero=1.
- srai x3,x1,4 (32'h4040D193) with rs1_data=32'h80000000 -> 32'hF8000000.
- sltu with A=32'hFFFFFFFF, B=1 -> 0.
- lui x5,0x12345 (32'h123452B7) -> wb_data=32'h12345000.
- csrrw x6,0xF00,x0 (32'hF0001373) with io_in=32'hA5 -> wb_data=32'hA5.
- csrrw x0,0xF02,x7 (32'hF0239073) with rs1_data=32'hCAFE -> hex_out=32'hCAFE next cycle, wb_we=0.
- hex_out holds on following NOPs.
- With RIU_MUL_EN: mulh, rs1_data=32'hFFFFFFFE (-2), rs2_data=3 -> 32'hFFFFFFFF.
- With RIU_MUL_EN: mulhu, rs1_data=32'hFFFFFFFE, rs2_data=3 -> 2.
- Without RIU_MUL_EN: the same instructions -> wb_we=0.

Source files
------------

// File: rtl/riu_pkg.sv
// riu_pkg: shared types and constants for the RIU RV32I-subset core.
//   aluop_e  - 4-bit ALU operation select
//   regsel_e - write-back source select
//   opcode / funct3 / funct7 constants and default CSR I/O addresses
// Optional feature macro used by the ALU and decoder: RIU_MUL_EN.
package riu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_ADD   = 4'd3,
    ALU_SUB   = 4'd4,
    ALU_MUL   = 4'd5,
    ALU_MULH  = 4'd6,
    ALU_MULHU = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd12,
    ALU_SLTU  = 4'd13
  } aluop_e;

  typedef enum logic [1:0] {
    REG_IN  = 2'b00,
    REG_LUI = 2'b01,
    REG_ALU = 2'b10
  } regsel_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SLT   = 3'b010;
  localparam logic [2:0] F3_SLTU  = 3'b011;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_SRL   = 3'b101;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULH  = 3'b001;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [11:0] CSR_IO_IN_DEF  = 12'hF00;
  localparam logic [11:0] CSR_IO_OUT_DEF = 12'hF02;

endpackage

// File: rtl/riu_alu.sv
// riu_alu: purely combinational ALU.
//   a, b   - operands (XLEN)
//   aluop  - operation select (riu_pkg::aluop_e)
//   r      - result, wraps modulo 2^XLEN
//   zero   - 1 when r == 0
// With RIU_MUL_EN defined the MUL/MULH/MULHU ops are built; otherwise
// those op codes return 0 and no multiplier exists.
module riu_alu
  import riu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  aluop_e          aluop,
  output logic [XLEN-1:0] r,
  output logic            zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign shamt = b[4:0];

`ifdef RIU_MUL_EN
  // One 2*XLEN multiply serves all three ops: operands are sign-extended
  // for MULH and zero-extended otherwise; the low half is identical.
  logic                     sext;
  logic [2*XLEN-1:0]        a_ext;
  logic [2*XLEN-1:0]        b_ext;
  logic [2*XLEN-1:0]        prod;

  assign sext  = (aluop == ALU_MULH);
  assign a_ext = {{XLEN{sext & a[XLEN-1]}}, a};
  assign b_ext = {{XLEN{sext & b[XLEN-1]}}, b};
  assign prod  = a_ext * b_ext;
`endif

  always_comb begin
    r = '0;
    case (aluop)
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
`ifdef RIU_MUL_EN
      ALU_MUL:   r = prod[XLEN-1:0];
      ALU_MULH:  r = prod[2*XLEN-1:XLEN];
      ALU_MULHU: r = prod[2*XLEN-1:XLEN];
`endif
      ALU_SLL:   r = a << shamt;
      ALU_SRL:   r = a >> shamt;
      ALU_SRA:   r = $unsigned(a_s >>> shamt);
      ALU_SLT:   r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
      default:   r = '0;
    endcase
  end

  assign zero = (r == '0);

endmodule

// File: rtl/riu_exec_stage.sv
// riu_exec_stage: decode, control and ALU execute stage of the RIU core,
// plus the one-cycle write-back register and the hex/GPIO output register.
// Ports:
//   clck                 - clock, rising edge
//   rst_n                - asynchronous reset, ACTIVE-HIGH (1 resets)
//   instr                - instruction in EX
//   rs1_data, rs2_data   - register-file read data
//   io_in                - switch/GPIO input (read by csrrw CSR_IO_IN)
//   rs1_addr, rs2_addr   - register-file read addresses
//   alu_result, alu_zero - combinational ALU outputs
//   wb_we, wb_rd, wb_data- registered write-back controls (latency 1)
//   hex_out              - registered GPIO value (written by csrrw CSR_IO_OUT)
// Optional feature macro: RIU_MUL_EN (mul/mulh/mulhu decode + multiplier).
module riu_exec_stage
  import riu_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [11:0] CSR_IO_IN  = CSR_IO_IN_DEF,
  parameter logic [11:0] CSR_IO_OUT = CSR_IO_OUT_DEF
) (
  input  logic            clck,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] io_in,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] hex_out
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic [19:0] imm20;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm12    = instr[31:20];
  assign imm20    = instr[31:12];

  logic    regwrite;
  logic    gpio_we;
  logic    alusrc;
  aluop_e  aluop;
  regsel_e regsel;

  // Any encoding not matched below falls through as a NOP.
  always_comb begin
    regwrite = 1'b0;
    gpio_we  = 1'b0;
    alusrc   = 1'b0;
    aluop    = ALU_ADD;
    regsel   = REG_ALU;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          regwrite = 1'b1;
          case (funct3)
            F3_ADD:  aluop = ALU_ADD;
            F3_SLL:  aluop = ALU_SLL;
            F3_SLT:  aluop = ALU_SLT;
            F3_SLTU: aluop = ALU_SLTU;
            F3_XOR:  aluop = ALU_XOR;
            F3_SRL:  aluop = ALU_SRL;
            F3_OR:   aluop = ALU_OR;
            default: aluop = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD) begin
            regwrite = 1'b1;
            aluop    = ALU_SUB;
          end else if (funct3 == F3_SRL) begin
            regwrite = 1'b1;
            aluop    = ALU_SRA;
          end
`ifdef RIU_MUL_EN
        end else if (funct7 == F7_MUL) begin
          if (funct3 == F3_MUL) begin
            regwrite = 1'b1;
            aluop    = ALU_MUL;
          end else if (funct3 == F3_MULH) begin
            regwrite = 1'b1;
            aluop    = ALU_MULH;
          end else if (funct3 == F3_MULHU) begin
            regwrite = 1'b1;
            aluop    = ALU_MULHU;
          end
`endif
        end
      end
      OP_I: begin
        case (funct3)
          F3_ADD:  begin regwrite = 1'b1; aluop = ALU_ADD;  end
          F3_SLT:  begin regwrite = 1'b1; aluop = ALU_SLT;  end
          F3_SLTU: begin regwrite = 1'b1; aluop = ALU_SLTU; end
          F3_XOR:  begin regwrite = 1'b1; aluop = ALU_XOR;  end
          F3_OR:   begin regwrite = 1'b1; aluop = ALU_OR;   end
          F3_AND:  begin regwrite = 1'b1; aluop = ALU_AND;  end
          F3_SLL: begin
            if (funct7 == F7_BASE) begin
              regwrite = 1'b1;
              aluop    = ALU_SLL;
            end
          end
          default: begin // F3_SRL: srli / srai chosen by imm[11:5]
            if (funct7 == F7_BASE) begin
              regwrite = 1'b1;
              aluop    = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              regwrite = 1'b1;
              aluop    = ALU_SRA;
            end
          end
        endcase
        // alusrc only matters when the instruction is actually executed
        alusrc = regwrite;
      end
      OP_LUI: begin
        regwrite = 1'b1;
        regsel   = REG_LUI;
      end
      OP_SYS: begin
        if (funct3 == F3_CSRRW) begin
          if (imm12 == CSR_IO_IN) begin
            regwrite = 1'b1;
            regsel   = REG_IN;
          end else if (imm12 == CSR_IO_OUT) begin
            gpio_we = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  logic signed [XLEN-1:0] imm_sext;
  logic [XLEN-1:0]        alu_b;

  assign imm_sext = {{(XLEN-12){imm12[11]}}, imm12};
  assign alu_b    = alusrc ? $unsigned(imm_sext) : rs2_data;

  riu_alu #(.XLEN(XLEN)) u_alu (
    .a     (rs1_data),
    .b     (alu_b),
    .aluop (aluop),
    .r     (alu_result),
    .zero  (alu_zero)
  );

  logic [XLEN-1:0] wb_src;

  always_comb begin
    case (regsel)
      REG_IN:  wb_src = io_in;
      REG_LUI: wb_src = {imm20, 12'b0};
      default: wb_src = alu_result;
    endcase
  end

  // ---- EX -> WB stage boundary ----
  logic            we_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] data_p1;
  logic [XLEN-1:0] hex_p1;

  always_ff @(posedge clck or posedge rst_n) begin
    if (rst_n) begin
      we_p1   <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      hex_p1  <= '0;
    end else begin
      we_p1   <= regwrite;
      rd_p1   <= rd;
      data_p1 <= wb_src;
      if (gpio_we) hex_p1 <= rs1_data;
    end
  end

  assign wb_we   = we_p1;
  assign wb_rd   = rd_p1;
  assign wb_data = data_p1;
  assign hex_out = hex_p1;

endmodule

// File: tb/tb_riu_exec_stage.sv
// tb_riu_exec_stage: directed-vector bench for riu_exec_stage.
// Covers reset, ALU/decode paths, LUI, CSR I/O, hex hold, the multiply
// option (RIU_MUL_EN on or off) and an asynchronous mid-operation reset.
module tb_riu_exec_stage;

  logic        clck = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] io_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] hex_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clck = ~clck;

  riu_exec_stage dut (
    .clck       (clck),
    .rst_n      (rst_n),
    .instr      (instr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .io_in      (io_in),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .hex_out    (hex_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clck);
    #1;
  endtask

  initial begin
    rst_n    = 1'b1;
    instr    = 32'h0;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    io_in    = 32'h0;
    step();
    step();
    chk("rst_wb_we",   {31'b0, wb_we}, 32'h0);
    chk("rst_wb_rd",   {27'b0, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_hex_out", hex_out, 32'h0);

    // combinational path still live under reset
    instr = 32'h00500093;
    #1;
    chk("rst_comb_alu", alu_result, 32'h5);
    step();
    chk("rst_hold_we", {31'b0, wb_we}, 32'h0);

    instr = 32'h0;
    rst_n = 1'b0;
    step();
    chk("nop_wb_we", {31'b0, wb_we}, 32'h0);

    // addi x1,x0,5
    instr = 32'h00500093;
    #1;
    chk("addi_alu",  alu_result, 32'h5);
    chk("addi_rs1a", {27'b0, rs1_addr}, 32'h0);
    chk("addi_rs2a", {27'b0, rs2_addr}, 32'h5);
    step();
    chk("addi_we",   {31'b0, wb_we}, 32'h1);
    chk("addi_rd",   {27'b0, wb_rd}, 32'h1);
    chk("addi_data", wb_data, 32'h5);

    // sub x2,x1,x2
    instr = 32'h40208133; rs1_data = 32'd3; rs2_data = 32'd5;
    #1;
    chk("sub_alu",  alu_result, 32'hFFFFFFFE);
    chk("sub_zero", {31'b0, alu_zero}, 32'h0);
    chk("sub_rs2a", {27'b0, rs2_addr}, 32'h2);
    step();
    chk("sub_data", wb_data, 32'hFFFFFFFE);
    chk("sub_rd",   {27'b0, wb_rd}, 32'h2);
    rs1_data = 32'd7; rs2_data = 32'd7;
    #1;
    chk("sub_eq_zero", {31'b0, alu_zero}, 32'h1);
    chk("sub_eq_alu",  alu_result, 32'h0);

    // srai x3,x1,4
    instr = 32'h4040D193; rs1_data = 32'h80000000;
    step();
    chk("srai_data", wb_data, 32'hF8000000);
    chk("srai_rd",   {27'b0, wb_rd}, 32'h3);

    // sltu / slt x4,x1,x2 with A=-1, B=1
    instr = 32'h0020B233; rs1_data = 32'hFFFFFFFF; rs2_data = 32'h1;
    #1;
    chk("sltu_alu", alu_result, 32'h0);
    step();
    chk("sltu_we",   {31'b0, wb_we}, 32'h1);
    chk("sltu_data", wb_data, 32'h0);
    instr = 32'h0020A233;
    #1;
    chk("slt_alu", alu_result, 32'h1);

    // lui x5,0x12345
    instr = 32'h123452B7;
    step();
    chk("lui_data", wb_data, 32'h12345000);
    chk("lui_rd",   {27'b0, wb_rd}, 32'h5);

    // csrrw x6,0xF00,x0
    instr = 32'hF0001373; io_in = 32'hA5; rs1_data = 32'h0;
    step();
    chk("csr_in_data", wb_data, 32'hA5);
    chk("csr_in_we",   {31'b0, wb_we}, 32'h1);
    chk("csr_in_rd",   {27'b0, wb_rd}, 32'h6);

    // csrrw x0,0xF02,x7
    instr = 32'hF0239073; rs1_data = 32'hCAFE;
    #1;
    chk("csr_out_pre", hex_out, 32'h0);
    step();
    chk("csr_out_hex", hex_out, 32'hCAFE);
    chk("csr_out_we",  {31'b0, wb_we}, 32'h0);

    // hex holds across NOPs
    instr = 32'h0; rs1_data = 32'h1234;
    step();
    step();
    chk("hex_hold",   hex_out, 32'hCAFE);
    chk("hold_nopwe", {31'b0, wb_we}, 32'h0);

    // multiply option: mulh then mulhu with -2, 3
    rs1_data = 32'hFFFFFFFE; rs2_data = 32'd3;
    instr = 32'h02209433;
`ifdef RIU_MUL_EN
    #1;
    chk("mulh_alu", alu_result, 32'hFFFFFFFF);
    step();
    chk("mulh_we",   {31'b0, wb_we}, 32'h1);
    chk("mulh_data", wb_data, 32'hFFFFFFFF);
    instr = 32'h0220B433;
    step();
    chk("mulhu_data", wb_data, 32'h2);
`else
    #1;
    chk("mulh_nop_alu", alu_result, 32'h1);
    step();
    chk("mulh_nop_we", {31'b0, wb_we}, 32'h0);
    instr = 32'h0220B433;
    step();
    chk("mulhu_nop_we", {31'b0, wb_we}, 32'h0);
`endif

    // asynchronous reset discards a pending write
    instr = 32'h00500093; rs1_data = 32'h0;
    step();
    chk("pre_rst_we", {31'b0, wb_we}, 32'h1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst_we",   {31'b0, wb_we}, 32'h0);
    chk("async_rst_data", wb_data, 32'h0);
    chk("async_rst_hex",  hex_out, 32'h0);
    step();
    rst_n = 1'b0;
    step();
    chk("post_rst_we", {31'b0, wb_we}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
